// File: rtl/wasm_cmp_unit_if.sv
// Handshake and data bundle for the Wasm comparison unit.
//   master: issues operations (in_valid, op, is64, a, b) and accepts results (out_ready).
//   slave : the comparison unit; returns in_ready, out_valid, result and trap.
interface wasm_cmp_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        is64;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [3:0]  trap;

  modport master (
    output in_valid, op, is64, a, b, out_ready,
    input  in_ready, out_valid, result, trap
  );

  modport slave (
    input  in_valid, op, is64, a, b, out_ready,
    output in_ready, out_valid, result, trap
  );
endinterface

// File: rtl/wasm_cmp_unit.sv
// Multi-cycle i32/i64 comparison unit (eqz, eq, ne, lt/gt/le/ge signed and unsigned).
// Operands are walked CHUNK bits per cycle, most significant chunk first; the first
// differing chunk decides the ordering. The result is the Wasm boolean zero-extended
// to 64 bits; an illegal opcode returns result 0 with trap = TRAP_BAD_OP.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - slave side of wasm_cmp_unit_if (in_valid/in_ready request with op, is64,
//           a, b; out_valid/out_ready response with result, trap)
module wasm_cmp_unit #(
  parameter int unsigned CHUNK       = 16,
  parameter bit          EARLY_EXIT  = 1'b1,
  parameter logic [3:0]  TRAP_BAD_OP = 4'd1
) (
  input logic            clk,
  input logic            reset,
  wasm_cmp_unit_if.slave bus
);

  localparam int unsigned N64 = 64 / CHUNK;
  localparam int unsigned N32 = 32 / CHUNK;

  localparam logic [3:0] OpEqz = 4'd0;
  localparam logic [3:0] OpEq  = 4'd1;
  localparam logic [3:0] OpNe  = 4'd2;
  localparam logic [3:0] OpLtS = 4'd3;
  localparam logic [3:0] OpLtU = 4'd4;
  localparam logic [3:0] OpGtS = 4'd5;
  localparam logic [3:0] OpGtU = 4'd6;
  localparam logic [3:0] OpLeS = 4'd7;
  localparam logic [3:0] OpLeU = 4'd8;
  localparam logic [3:0] OpGeS = 4'd9;
  localparam logic [3:0] OpGeU = 4'd10;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic        is64_q;
  logic        bad_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [6:0]  cnt_q;
  logic        diff_q;
  logic        gt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [63:0] result_q;
  logic [3:0]  trap_q;

  logic             signed_op;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             chunk_ne;
  logic             diff_d;
  logic             gt_d;
  logic [6:0]       last_idx;
  logic             finish;
  logic             res_bit;

  always_comb begin
    signed_op = (op_q == OpLtS) || (op_q == OpGtS) || (op_q == OpLeS) || (op_q == OpGeS);
    a_chunk   = a_q[63 -: CHUNK];
    b_chunk   = b_q[63 -: CHUNK];
    // Flipping the sign bit on the top chunk turns a signed order into an unsigned one.
    if (signed_op && (cnt_q == '0)) begin
      a_chunk[CHUNK-1] = ~a_chunk[CHUNK-1];
      b_chunk[CHUNK-1] = ~b_chunk[CHUNK-1];
    end
    chunk_ne = (a_chunk != b_chunk);
    diff_d   = diff_q | chunk_ne;
    // Only the first differing chunk decides the ordering.
    gt_d     = diff_q ? gt_q : (a_chunk > b_chunk);
    last_idx = is64_q ? 7'(N64 - 1) : 7'(N32 - 1);
    finish   = (cnt_q == last_idx) || (EARLY_EXIT && chunk_ne);

    res_bit = 1'b0;
    case (op_q)
      OpEqz, OpEq:  res_bit = ~diff_d;
      OpNe:         res_bit = diff_d;
      OpLtS, OpLtU: res_bit = diff_d & ~gt_d;
      OpGtS, OpGtU: res_bit = diff_d & gt_d;
      OpLeS, OpLeU: res_bit = ~(diff_d & gt_d);
      OpGeS, OpGeU: res_bit = ~(diff_d & ~gt_d);
      default:      res_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      is64_q      <= 1'b0;
      bad_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      diff_q      <= 1'b0;
      gt_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      trap_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_q   <= bus.op;
            is64_q <= bus.is64;
            bad_q  <= (bus.op > OpGeU);
            // i32 operands are left-aligned so the MSB chunk always sits at bit 63.
            a_q    <= bus.is64 ? bus.a : {bus.a[31:0], 32'h0};
            if (bus.op == OpEqz) begin
              b_q <= '0;
            end else begin
              b_q <= bus.is64 ? bus.b : {bus.b[31:0], 32'h0};
            end
            cnt_q      <= '0;
            diff_q     <= 1'b0;
            gt_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (bad_q) begin
            // Illegal op: no chunks are compared, straight to the trap response.
            result_q    <= '0;
            trap_q      <= TRAP_BAD_OP;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            diff_q <= diff_d;
            gt_q   <= gt_d;
            a_q    <= a_q << CHUNK;
            b_q    <= b_q << CHUNK;
            cnt_q  <= cnt_q + 7'd1;
            if (finish) begin
              result_q    <= {63'h0, res_bit};
              trap_q      <= '0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.trap      = trap_q;

endmodule

// File: tb/tb_wasm_cmp_unit.sv
// Self-checking bench for wasm_cmp_unit: four instances with different CHUNK/EARLY_EXIT
// settings, a directed vector table, hand-written handshake/reset sequences and random
// operations checked against an arithmetic reference model.
module tb_wasm_cmp_unit;

  localparam int NDUT = 4;
  localparam int unsigned CH [NDUT] = '{16, 16, 1, 32};
  localparam bit          EE [NDUT] = '{1'b1, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NDUT-1:0] in_valid_s, is64_s, out_ready_s, in_ready_s, out_valid_s;
  logic [3:0]      op_s     [NDUT];
  logic [63:0]     a_s      [NDUT];
  logic [63:0]     b_s      [NDUT];
  logic [63:0]     result_s [NDUT];
  logic [3:0]      trap_s   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wasm_cmp_unit_if u_if ();
    assign u_if.in_valid  = in_valid_s[g];
    assign u_if.op        = op_s[g];
    assign u_if.is64      = is64_s[g];
    assign u_if.a         = a_s[g];
    assign u_if.b         = b_s[g];
    assign u_if.out_ready = out_ready_s[g];
    assign in_ready_s[g]  = u_if.in_ready;
    assign out_valid_s[g] = u_if.out_valid;
    assign result_s[g]    = u_if.result;
    assign trap_s[g]      = u_if.trap;

    wasm_cmp_unit #(
      .CHUNK       (CH[g]),
      .EARLY_EXIT  (EE[g]),
      .TRAP_BAD_OP (4'd1)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain Wasm semantics plus the chunk-position latency rule.
  function automatic void model(input int unsigned ch, input bit ee, input logic [3:0] op,
                                input bit is64, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output logic [3:0] trap,
                                output int edges);
    int          w;
    int          msb;
    logic [63:0] av, bv, x;
    longint      sa, sb;
    bit          r;
    if (op > 4'd10) begin
      res   = '0;
      trap  = 4'd1;
      edges = 1;
      return;
    end
    w  = is64 ? 64 : 32;
    av = is64 ? a : {32'h0, a[31:0]};
    bv = (op == 4'd0) ? 64'h0 : (is64 ? b : {32'h0, b[31:0]});
    sa = is64 ? longint'($signed(av)) : longint'($signed(av[31:0]));
    sb = is64 ? longint'($signed(bv)) : longint'($signed(bv[31:0]));
    case (op)
      4'd0, 4'd1: r = (av == bv);
      4'd2:       r = (av != bv);
      4'd3:       r = (sa < sb);
      4'd4:       r = (av < bv);
      4'd5:       r = (sa > sb);
      4'd6:       r = (av > bv);
      4'd7:       r = (sa <= sb);
      4'd8:       r = (av <= bv);
      4'd9:       r = (sa >= sb);
      default:    r = (av >= bv);
    endcase
    res   = {63'h0, r};
    trap  = 4'd0;
    edges = w / int'(ch);
    if (ee && (av != bv)) begin
      x   = av ^ bv;
      msb = 0;
      for (int i = 0; i < 64; i++) if (x[i]) msb = i;
      edges = (w - 1 - msb) / int'(ch) + 1;
    end
  endfunction

  task automatic wait_idle(input int s);
    int w = 0;
    @(negedge clk);
    while (!in_ready_s[s] && w < 200) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Issue one op with out_ready=1; returns the response and the edges from acceptance.
  task automatic do_op(input int s, input logic [3:0] op, input bit is64,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic [3:0] trap, output int edges);
    wait_idle(s);
    chk($sformatf("dut%0d_in_ready_at_accept", s), in_ready_s[s], 1);
    in_valid_s[s]  = 1'b1;
    op_s[s]        = op;
    is64_s[s]      = is64;
    a_s[s]         = a;
    b_s[s]         = b;
    out_ready_s[s] = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs while busy; they must not affect the result.
    in_valid_s[s] = 1'b0;
    op_s[s]       = 4'($urandom);
    a_s[s]        = {$urandom, $urandom};
    b_s[s]        = {$urandom, $urandom};
    edges = 0;
    while (!out_valid_s[s] && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    res  = result_s[s];
    trap = trap_s[s];
  endtask

  typedef struct {
    logic [3:0]  op;
    bit          is64;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  trap;
    int          edges;
  } vec_t;

  initial begin
    vec_t        vecs [$];
    logic [63:0] r, er, held, ra, rb;
    logic [3:0]  t, et, rop;
    int          e, ee_, s, w;
    bit          r64;

    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [$];
    logic [63:0] r, er, held, ra, rb;
    logic [3:0]  t, et, rop;
    int          e, ee_, s, w;
    bit          r64;

    reset = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      in_valid_s[i]  = 1'b0;
      is64_s[i]      = 1'b0;
      out_ready_s[i] = 1'b0;
      op_s[i]        = '0;
      a_s[i]         = '0;
      b_s[i]         = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("dut%0d_reset_in_ready", i), in_ready_s[i], 1);
      chk($sformatf("dut%0d_reset_out_valid", i), out_valid_s[i], 0);
      chk($sformatf("dut%0d_reset_result", i), result_s[i], 0);
      chk($sformatf("dut%0d_reset_trap", i), trap_s[i], 0);
    end
    reset = 1'b0;

    // Directed vectors on the default instance (CHUNK=16, EARLY_EXIT=1).
    vecs.push_back('{4'd0,  1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 4});
    vecs.push_back('{4'd0,  1'b1, 64'h1_0000_0000, 64'h0, 64'd0, 4'd0, 2});
    vecs.push_back('{4'd0,  1'b0, 64'hFFFF_FFFF_0000_0000, 64'h5, 64'd1, 4'd0, 2});
    vecs.push_back('{4'd3,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'd1, 4'd0, 1});
    vecs.push_back('{4'd4,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'd0, 4'd0, 1});
    vecs.push_back('{4'd10, 1'b1, 64'h1234, 64'h1234, 64'd1, 4'd0, 4});
    vecs.push_back('{4'd12, 1'b1, 64'h0, 64'h0, 64'd0, 4'd1, 1});
    vecs.push_back('{4'd5,  1'b0, 64'hDEAD_BEEF_8000_0000, 64'h1, 64'd0, 4'd0, 1});
    vecs.push_back('{4'd2,  1'b1, 64'h1, 64'h0, 64'd1, 4'd0, 4});
    vecs.push_back('{4'd6,  1'b0, 64'h0001_0000, 64'h0000_FFFF, 64'd1, 4'd0, 1});
    vecs.push_back('{4'd8,  1'b1, 64'hFFFF_0000_0000_0000, 64'h0, 64'd0, 4'd0, 1});
    vecs.push_back('{4'd9,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'd0, 4'd0, 1});
    vecs.push_back('{4'd1,  1'b0, 64'h1_0000_0007, 64'h7, 64'd1, 4'd0, 2});
    vecs.push_back('{4'd15, 1'b0, 64'h5, 64'h5, 64'd0, 4'd1, 1});
    vecs.push_back('{4'd7,  1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1});
    vecs.push_back('{4'd9,  1'b0, 64'h0000_0000_0001_0005, 64'hFFFF_FFFF_0001_0004, 64'd1, 4'd0, 2});
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(0, vecs[i].op, vecs[i].is64, vecs[i].a, vecs[i].b, r, t, e);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_trap", i), 64'(t), 64'(vecs[i].trap));
      chk($sformatf("vec%0d_edges", i), 64'(e), 64'(vecs[i].edges));
    end

    // Fixed latency without early exit.
    do_op(1, 4'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, r, t, e);
    chk("ee0_lt_s_result", r, 1);
    chk("ee0_lt_s_edges", 64'(e), 4);
    do_op(1, 4'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, r, t, e);
    chk("ee0_lt_u_result", r, 0);
    chk("ee0_lt_u_edges", 64'(e), 4);
    // Chunk-width extremes.
    do_op(2, 4'd1, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0, r, t, e);
    chk("chunk1_eq64_result", r, 1);
    chk("chunk1_eq64_edges", 64'(e), 64);
    do_op(2, 4'd4, 1'b0, 64'h0, 64'h1, r, t, e);
    chk("chunk1_lt_u32_result", r, 1);
    chk("chunk1_lt_u32_edges", 64'(e), 32);
    do_op(3, 4'd10, 1'b0, 64'h3, 64'h3, r, t, e);
    chk("chunk32_ge_u32_result", r, 1);
    chk("chunk32_ge_u32_edges", 64'(e), 1);
    do_op(3, 4'd1, 1'b1, 64'h77, 64'h77, r, t, e);
    chk("chunk32_eq64_edges", 64'(e), 2);

    // Backpressure: result held for 5 cycles, second request waits for the handoff.
    wait_idle(0);
    in_valid_s[0] = 1'b1; op_s[0] = 4'd6; is64_s[0] = 1'b1;
    a_s[0] = 64'h5; b_s[0] = 64'h3; out_ready_s[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    w = 0;
    while (!out_valid_s[0] && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    held = result_s[0];
    chk("bp_result", held, 1);
    in_valid_s[0] = 1'b1; op_s[0] = 4'd1; a_s[0] = 64'h9; b_s[0] = 64'h8;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_out_valid", i), out_valid_s[0], 1);
      chk($sformatf("bp_hold%0d_result", i), result_s[0], 1);
      chk($sformatf("bp_hold%0d_in_ready", i), in_ready_s[0], 0);
    end
    @(negedge clk);
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handoff_out_valid", out_valid_s[0], 0);
    chk("bp_handoff_in_ready", in_ready_s[0], 1);
    chk("bp_handoff_result_kept", result_s[0], 1);
    @(posedge clk);
    #1;
    chk("bp_second_accepted", in_ready_s[0], 0);
    in_valid_s[0] = 1'b0;
    e = 0;
    while (!out_valid_s[0] && e < 300) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk("bp_second_result", result_s[0], 0);
    chk("bp_second_edges", 64'(e), 4);

    // Reset during the second BUSY cycle aborts the operation.
    wait_idle(0);
    in_valid_s[0] = 1'b1; op_s[0] = 4'd1; is64_s[0] = 1'b1;
    a_s[0] = 64'h0; b_s[0] = 64'h0; out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_mid_in_ready", in_ready_s[0], 1);
    chk("rst_mid_out_valid", out_valid_s[0], 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_mid_quiet%0d", i), out_valid_s[0], 0);
    end
    do_op(0, 4'd1, 1'b1, 64'h5, 64'h5, r, t, e);
    chk("rst_after_eq_result", r, 1);
    chk("rst_after_eq_edges", 64'(e), 4);

    // Random operations against the reference model.
    for (int i = 0; i < 160; i++) begin
      s   = $urandom_range(0, NDUT - 1);
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      r64 = 1'($urandom);
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (64'h1 << $urandom_range(0, 63));
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) ra = '0;
      model(CH[s], EE[s], rop, r64, ra, rb, er, et, ee_);
      do_op(s, rop, r64, ra, rb, r, t, e);
      chk($sformatf("rnd%0d_dut%0d_op%0d_result", i, s, rop), r, er);
      chk($sformatf("rnd%0d_dut%0d_op%0d_trap", i, s, rop), 64'(t), 64'(et));
      chk($sformatf("rnd%0d_dut%0d_op%0d_edges", i, s, rop), 64'(e), 64'(ee_));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
